spi_cmd_bridge: RTL

//  Consumes received bytes from spislave (mdata/data_valid_read/data_firstbyte) and drives its

---
 rtl/spi_cmd_bridge.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_bridge.sv
`default_nettype none
// ============================================================================
// spi_cmd_bridge: decodes SPI command/address bytes into auto-incrementing
// write/read bursts on a ready-handshake bus.           Revision: 1.0
// ============================================================================
module spi_cmd_bridge #(
    parameter int         ADDR_W    = 15,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_first,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic              err_overrun
);

    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    typedef enum logic [2:0] {
        ST_CMD    = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WDATA  = 3'd2,
        ST_RDUMMY = 3'd3,
        ST_RDATA  = 3'd4
    } state_t;

    state_t            state_q,     state_d;
    logic              rw_q,        rw_d;
    logic [6:0]        addr_hi_q,   addr_hi_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              we_q,        we_d;
    logic              re_q,        re_d;
    logic [7:0]        tx_q,        tx_d;
    logic              err_q,       err_d;
    logic              stale_q,     stale_d;
    logic              defer_q,     defer_d;

    logic [14:0]       w_full_addr;
    logic              w_pending;

    assign w_full_addr = {addr_hi_q, rx_data};

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        addr_hi_d   = addr_hi_q;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        we_d        = we_q;
        re_d        = re_q;
        tx_d        = tx_q;
        err_d       = err_q;
        stale_d     = stale_q;
        defer_d     = defer_q;

        // Completion is handled before the incoming byte so a same-cycle byte sees a free bus.
        if ((we_q || re_q) && mem_ready) begin
            we_d    = 1'b0;
            re_d    = 1'b0;
            stale_d = 1'b0;
            if (!stale_q) begin
                addr_d = addr_q + c_addr_one;
                if (re_q) begin
                    tx_d = mem_rdata;
                end
            end
            // A read whose address arrived while an abandoned op still owned the bus.
            if (defer_q) begin
                re_d       = 1'b1;
                mem_addr_d = addr_d;
                defer_d    = 1'b0;
            end
        end

        w_pending = we_d || re_d;

        if (rx_valid) begin
            if (rx_first || state_q == ST_CMD) begin
                rw_d      = rx_data[7];
                addr_hi_d = rx_data[6:0];
                err_d     = 1'b0;
                tx_d      = IDLE_BYTE;
                stale_d   = w_pending;
                defer_d   = 1'b0;
                state_d   = ST_ADDR;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        addr_d = w_full_addr[ADDR_W-1:0];
                        if (rw_q) begin
                            state_d = ST_WDATA;
                        end else begin
                            state_d = ST_RDUMMY;
                            if (w_pending) begin
                                defer_d = 1'b1;
                            end else begin
                                re_d       = 1'b1;
                                mem_addr_d = w_full_addr[ADDR_W-1:0];
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (w_pending) begin
                            err_d = 1'b1;
                        end else begin
                            we_d        = 1'b1;
                            mem_addr_d  = addr_d;
                            mem_wdata_d = rx_data;
                        end
                    end
                    default: begin
                        if (w_pending) begin
                            err_d = 1'b1;
                        end else begin
                            re_d       = 1'b1;
                            mem_addr_d = addr_d;
                            state_d    = ST_RDATA;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CMD;
            rw_q        <= 1'b0;
            addr_hi_q   <= 7'd0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            tx_q        <= IDLE_BYTE;
            err_q       <= 1'b0;
            stale_q     <= 1'b0;
            defer_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_hi_q   <= addr_hi_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            tx_q        <= tx_d;
            err_q       <= err_d;
            stale_q     <= stale_d;
            defer_q     <= defer_d;
        end
    end

    assign tx_data     = tx_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = we_q;
    assign mem_re      = re_q;
    assign err_overrun = err_q;

endmodule

`default_nettype wire
